// File: rtl/alu_cmd_sequencer_if.sv
// rtl/alu_cmd_sequencer_if.sv - command/result handshake bundle for alu_cmd_sequencer
//
// Purpose : groups the command channel (valid/ready + opcode/operand) and the
//           result channel (valid/ready + data) of the ALU command sequencer.
// Modports:
//   master - controller side: drives commands, consumes results
//   slave  - sequencer side: accepts commands, produces results
// Signals :
//   cmd_valid   master->slave  command present
//   cmd_ready   slave->master  sequencer can accept a command
//   cmd_op      master->slave  ALU opcode (OP_W)
//   cmd_operand master->slave  B operand (DATA_W)
//   res_valid   slave->master  result available
//   res_ready   master->slave  consumer accepts result
//   res_data    slave->master  result (DATA_W)

interface alu_cmd_sequencer_if #(
    parameter int DATA_W = 4,
    parameter int OP_W   = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [DATA_W-1:0] cmd_operand;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;

    modport master (
        output cmd_valid, cmd_op, cmd_operand, res_ready,
        input  cmd_ready, res_valid, res_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_operand, res_ready,
        output cmd_ready, res_valid, res_data
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - accumulator-machine front-end for a combinational ALU
//
// Purpose : accepts opcode+operand commands, drives the external combinational
//           ALU with A = accumulator and B = command operand, captures F back
//           into the accumulator and returns each result over a handshake.
//           Flow per command: IDLE (accept) -> EXEC (ALU evaluated, capture)
//           -> RESP (result held until accepted).
// Ports   :
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   bus        slave modport of alu_cmd_sequencer_if (cmd_* / res_* channels)
//   acc_clear  in   synchronous accumulator clear (wins over EXEC capture)
//   alu_s      out  ALU select (latched opcode)
//   alu_a      out  ALU A (always the accumulator)
//   alu_b      out  ALU B (latched operand)
//   alu_f      in   ALU result
//   res_zero   out  (ALU_SEQ_STATUS_EN only) res_data == 0
//   op_count   out  (ALU_SEQ_STATUS_EN only) saturating count of result handshakes
// Options : define ALU_SEQ_STATUS_EN to add res_zero and op_count.

module alu_cmd_sequencer #(
    parameter int DATA_W = 4,
    parameter int OP_W   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_cmd_sequencer_if.slave   bus,
    input  logic                 acc_clear,
    output logic [OP_W-1:0]      alu_s,
    output logic [DATA_W-1:0]    alu_a,
    output logic [DATA_W-1:0]    alu_b,
    input  logic [DATA_W-1:0]    alu_f
`ifdef ALU_SEQ_STATUS_EN
    ,
    output logic                 res_zero,
    output logic [7:0]           op_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_q,   state_d;
    logic [DATA_W-1:0] acc_q,     acc_d;
    logic [OP_W-1:0]   op_q,      op_d;
    logic [DATA_W-1:0] operand_q, operand_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            op_q      <= '0;
            operand_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            op_q      <= op_d;
            operand_q <= operand_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        op_d          = op_q;
        operand_d     = operand_q;
        bus.cmd_ready = 1'b0;
        bus.res_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    op_d      = bus.cmd_op;
                    operand_d = bus.cmd_operand;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                acc_d   = alu_f;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clear overrides the EXEC capture, so a colliding op reports 0.
        if (acc_clear) begin
            acc_d = '0;
        end
    end

    // The ALU operands hold their latched values outside EXEC; F is only
    // captured in EXEC, so its value elsewhere is irrelevant.
    assign alu_s        = op_q;
    assign alu_b        = operand_q;
    assign alu_a        = acc_q;
    assign bus.res_data = acc_q;

`ifdef ALU_SEQ_STATUS_EN
    logic [7:0] op_count_q, op_count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    always_comb begin
        op_count_d = op_count_q;
        if (state_q == ST_RESP && bus.res_ready && op_count_q != 8'hFF) begin
            op_count_d = op_count_q + 8'd1;
        end
    end

    assign res_zero = (acc_q == '0);
    assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed self-checking bench for alu_cmd_sequencer

module tb_alu_cmd_sequencer;

    localparam int DATA_W = 4;
    localparam int OP_W   = 3;

    logic              clk;
    logic              rst_n;
    logic              acc_clear;
    logic [OP_W-1:0]   alu_s;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_f;
`ifdef ALU_SEQ_STATUS_EN
    logic              res_zero;
    logic [7:0]        op_count;
`endif

    int errors = 0;
    int checks = 0;

    alu_cmd_sequencer_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();

    alu_cmd_sequencer #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .acc_clear (acc_clear),
        .alu_s     (alu_s),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_f     (alu_f)
`ifdef ALU_SEQ_STATUS_EN
        ,
        .res_zero  (res_zero),
        .op_count  (op_count)
`endif
    );

    // External combinational ALU
    always_comb begin
        case (alu_s)
            3'd0:    alu_f = 4'h0;
            3'd1:    alu_f = alu_b - alu_a;
            3'd2:    alu_f = alu_a - alu_b;
            3'd3:    alu_f = alu_a + alu_b;
            3'd4:    alu_f = alu_a ^ alu_b;
            3'd5:    alu_f = alu_a | alu_b;
            3'd6:    alu_f = alu_a & alu_b;
            default: alu_f = 4'hF;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command from IDLE; returns in RESP (one cycle after EXEC).
    task automatic issue(input logic [2:0] op, input logic [3:0] opnd);
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = op;
        bus.cmd_operand = opnd;
        step();
        bus.cmd_valid = 1'b0;
        step();
    endtask

    // Full command with res_ready high: check response, then back in IDLE.
    task automatic do_cmd(input string tag, input logic [2:0] op, input logic [3:0] opnd,
                          input logic [3:0] exp);
        bus.res_ready = 1'b1;
        issue(op, opnd);
        chk({tag, "_valid"}, {7'd0, bus.res_valid}, 8'd1);
        chk({tag, "_data"},  {4'd0, bus.res_data},  {4'd0, exp});
        step();
        chk({tag, "_idle"},  {7'd0, bus.cmd_ready}, 8'd1);
    endtask

    initial begin
        rst_n           = 1'b0;
        acc_clear       = 1'b0;
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = '0;
        bus.cmd_operand = '0;
        bus.res_ready   = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_cmd_ready", {7'd0, bus.cmd_ready}, 8'd1);
        chk("rst_res_valid", {7'd0, bus.res_valid}, 8'd0);
        chk("rst_alu_s",     {5'd0, alu_s},         8'd0);
        chk("rst_alu_b",     {4'd0, alu_b},         8'd0);
        chk("rst_res_data",  {4'd0, bus.res_data},  8'd0);
        rst_n = 1'b1;
        step();

        // First command: 0 + 5
        bus.res_ready   = 1'b1;
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = 3'd3;
        bus.cmd_operand = 4'd5;
        step();
        bus.cmd_valid = 1'b0;
        chk("exec_cmd_ready", {7'd0, bus.cmd_ready}, 8'd0);
        chk("exec_res_valid", {7'd0, bus.res_valid}, 8'd0);
        chk("exec_alu_s",     {5'd0, alu_s},         8'd3);
        chk("exec_alu_a",     {4'd0, alu_a},         8'd0);
        chk("exec_alu_b",     {4'd0, alu_b},         8'd5);
        step();
        chk("first_valid",     {7'd0, bus.res_valid}, 8'd1);
        chk("first_data",      {4'd0, bus.res_data},  8'd5);
        chk("first_cmd_ready", {7'd0, bus.cmd_ready}, 8'd0);
        step();
        chk("first_idle", {7'd0, bus.cmd_ready}, 8'd1);

        // Subtraction wrap
        do_cmd("sub_a_b", 3'd2, 4'd7, 4'hE);
        do_cmd("sub_b_a", 3'd1, 4'd3, 4'h5);

        // Backpressure: 5 + 1 = 6 held for 4 cycles; concurrent command ignored
        bus.res_ready = 1'b0;
        issue(3'd3, 4'd1);
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = 3'd7;
        bus.cmd_operand = 4'd0;
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid",     {7'd0, bus.res_valid}, 8'd1);
            chk("bp_data",      {4'd0, bus.res_data},  8'd6);
            chk("bp_cmd_ready", {7'd0, bus.cmd_ready}, 8'd0);
            step();
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        step();
        chk("bp_release_ready", {7'd0, bus.cmd_ready}, 8'd1);
        chk("bp_release_valid", {7'd0, bus.res_valid}, 8'd0);
        chk("bp_acc_kept",      {4'd0, alu_a},         8'd6);

        // Clear colliding with EXEC capture of op=7
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = 3'd7;
        bus.cmd_operand = 4'd0;
        step();
        bus.cmd_valid = 1'b0;
        acc_clear     = 1'b1;
        step();
        acc_clear = 1'b0;
        chk("clr_exec_valid", {7'd0, bus.res_valid}, 8'd1);
        chk("clr_exec_data",  {4'd0, bus.res_data},  8'd0);
        step();
        do_cmd("after_clr", 3'd3, 4'd2, 4'd2);

        // Clear during RESP: 2 ^ 3 = 1, then forced to 0 while still valid
        bus.res_ready = 1'b0;
        issue(3'd4, 4'd3);
        chk("resp_pre_clr", {4'd0, bus.res_data}, 8'd1);
        acc_clear = 1'b1;
        step();
        acc_clear = 1'b0;
        chk("resp_clr_valid", {7'd0, bus.res_valid}, 8'd1);
        chk("resp_clr_data",  {4'd0, bus.res_data},  8'd0);
        bus.res_ready = 1'b1;
        step();

        // Reset mid-operation: 0 + 9 held in RESP, then async reset
        do_cmd("and_zero", 3'd6, 4'hF, 4'h0);
        bus.res_ready = 1'b0;
        issue(3'd3, 4'd9);
        chk("mid_pre_data", {4'd0, bus.res_data}, 8'd9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {7'd0, bus.res_valid}, 8'd0);
        chk("mid_rst_acc",   {4'd0, alu_a},         8'd0);
        chk("mid_rst_ready", {7'd0, bus.cmd_ready}, 8'd1);
        step();
        rst_n = 1'b1;
        step();
        do_cmd("post_rst_or", 3'd5, 4'hA, 4'hA);

`ifdef ALU_SEQ_STATUS_EN
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("cnt_reset", op_count, 8'd0);
        for (int i = 0; i < 256; i++) begin
            bus.res_ready = 1'b1;
            issue(3'd0, 4'h3);
            chk("zero_flag", {7'd0, res_zero}, 8'd1);
            step();
            if (i == 0) chk("cnt_first", op_count, 8'd1);
        end
        chk("cnt_sat", op_count, 8'd255);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Sequential front-end for the 4-bit combinational ALU (3-bit op select, operands A/B, result F).
- Accepts opcode+operand commands over a valid/ready handshake and drives the ALU with A = internal accumulator, B = command operand.
- Captures F back into the accumulator and returns each result over a second valid/ready handshake.
- Converts the purely combinational ALU into an accumulator machine usable from a sequential controller.

Parameters:
- DATA_W, 4, operand/accumulator/result width; must match the ALU width.
- OP_W, 3, opcode width; must match the ALU select width.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  OP_W  ALU opcode: 0 zero, 1 B-A, 2 A-B, 3 A+B, 4 xor, 5 or, 6 and, 7 all-ones.
- cmd_operand  input  DATA_W  B operand.
- acc_clear  input  1  synchronous accumulator clear.
- alu_s  output  OP_W  to ALU select.
- alu_a  output  DATA_W  to ALU A (always = accumulator).
- alu_b  output  DATA_W  to ALU B.
- alu_f  input  DATA_W  from ALU result (combinational).
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_data  output  DATA_W  result (= accumulator after the op).

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; accumulator = 0; latched op/operand = 0.
  - cmd_ready=1, res_valid=0, alu_s=0, alu_b=0, res_data=0.
  - Reset mid-operation discards the in-flight command; no result is emitted.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch cmd_op/cmd_operand and go to EXEC. Otherwise stay.
  - EXEC: cmd_ready=0; alu_s/alu_b driven from the latches, alu_a = accumulator. At the end of the cycle the accumulator loads alu_f. Go to RESP.
  - RESP: res_valid=1, res_data=accumulator, held stable until res_ready. On res_valid&&res_ready go to IDLE.
- Latency and throughput:
  - Command accepted at edge N; ALU evaluated in cycle N+1; res_valid high from cycle N+2.
  - With res_ready tied high, one command per 3 cycles.
  - cmd_ready is high only in IDLE; there is no skid buffer.
- Outside EXEC, alu_s/alu_b hold their last latched values; consumers must not rely on F outside EXEC.
- Arithmetic:
  - All results are truncated modulo 2^DATA_W; no carry or borrow out.
  - Subtraction wraps, e.g. 5-7 = 4'hE.
- acc_clear:
  - Clears the accumulator at the next edge in any state.
  - If it coincides with the EXEC capture, clear wins: accumulator = 0 and the response carries 0.
  - In RESP, res_data changes to 0 while res_valid stays high; this is the one permitted change of res_data during RESP.
- res_ready while res_valid=0 is ignored.
- cmd_valid outside IDLE is ignored; the command is not consumed.

Optional Feature:
- Macro: ALU_SEQ_STATUS_EN.
- Defined: adds output res_zero (1 bit) and output op_count (8 bits).
  - res_zero is high whenever res_data==0, valid alongside res_valid.
  - op_count increments once per completed response handshake and saturates at 255.
  - op_count resets to 0 on rst_n; acc_clear does not affect it.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then a command is driven:
  - Release rst_n, then send op=3 operand=5 with res_ready=1.
  - cmd_ready drops the cycle after accept; alu_s=3, alu_a=0, alu_b=5 in EXEC.
  - res_valid=1 with res_data=5 two cycles after accept.
- Subtraction wrap:
  - With accumulator=5, send op=2 operand=7 → res_data=4'hE.
  - Then op=1 operand=3 → res_data=3-14 mod 16 = 4'h5.
- Backpressure:
  - Hold res_ready=0 for 4 cycles after res_valid.
  - res_valid and res_data stay stable; cmd_ready stays 0; a concurrent cmd_valid is not consumed.
  - Release res_ready → IDLE next cycle and cmd_ready=1.
- Clear collision:
  - Assert acc_clear in the EXEC cycle of op=7 → response res_data=0 (not 4'hF).
  - A following op=3 operand=2 → 2.
- Reset mid-operation:
  - Pulse rst_n low during RESP with res_data=9.
  - res_valid=0 immediately (async), accumulator=0; after release, op=5 operand=4'hA → 4'hA.
- With ALU_SEQ_STATUS_EN:
  - 256 ops with op=0 → res_zero=1 on each response; op_count saturates at 255.
